// File: rtl/ocx_tlx_fifo_drain_arb_if.sv
// Bundles the two FIFO head/pop pairs and the downstream valid/ready output of the drain arbiter.
// The master side is the arbiter; the slave side is the FIFO pair plus the consumer.
interface ocx_tlx_fifo_drain_arb_if #(
    parameter int DATA_WIDTH = 514
);
    logic                  src0_avail;
    logic [DATA_WIDTH-1:0] src0_data;
    logic                  src0_rd_done;
    logic                  src1_avail;
    logic [DATA_WIDTH-1:0] src1_data;
    logic                  src1_rd_done;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_src;
    logic                  out_ready;
    logic [15:0]           pop_cnt0;
    logic [15:0]           pop_cnt1;

    modport master (
        input  src0_avail, src0_data, src1_avail, src1_data, out_ready,
        output src0_rd_done, src1_rd_done, out_valid, out_data, out_src,
               pop_cnt0, pop_cnt1
    );

    modport slave (
        output src0_avail, src0_data, src1_avail, src1_data, out_ready,
        input  src0_rd_done, src1_rd_done, out_valid, out_data, out_src,
               pop_cnt0, pop_cnt1
    );
endinterface

// File: rtl/ocx_tlx_fifo_drain_arb.sv
// Drains two TLX receive FIFO heads into one registered valid/ready output, popping each winner.
// Define OCX_TLX_DRAIN_ARB_STRICT_PRIO_EN for fixed src0 priority; default build is round-robin.
module ocx_tlx_fifo_drain_arb #(
    parameter int DATA_WIDTH  = 514,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                     clock,
    input  logic                     reset_n,
    ocx_tlx_fifo_drain_arb_if.master bus
);
    localparam int NSRC   = 2;
    localparam int HOLD_W = 2;
    // The load cycle itself counts as the first of HOLD_CYCLES+1 blocked cycles,
    // so the register only needs to cover the cycles after the load edge.
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_t;

    out_state_t                       state_reg, state_next;
    logic [DATA_WIDTH-1:0]            out_data_reg, out_data_next;
    logic                             out_src_reg, out_src_next;
    logic [NSRC-1:0]                  rd_done_reg, rd_done_next;
    logic [NSRC-1:0][HOLD_W-1:0]      hold_reg, hold_next;
    logic [NSRC-1:0][15:0]            pop_cnt_reg, pop_cnt_next;
    logic [NSRC-1:0]                  avail;
    logic [NSRC-1:0]                  elig;
    logic [NSRC-1:0][DATA_WIDTH-1:0]  src_data;
    logic                             load_ok;
    logic                             load_en;
    logic                             winner;

    assign avail    = {bus.src1_avail, bus.src0_avail};
    assign src_data = {bus.src1_data, bus.src0_data};

    genvar gi;
    generate
        for (gi = 0; gi < NSRC; gi++) begin : g_elig
            assign elig[gi] = avail[gi] & (hold_reg[gi] == '0);
        end
    endgenerate

`ifdef OCX_TLX_DRAIN_ARB_STRICT_PRIO_EN
    always_comb begin
        winner = ~elig[0];
    end
`else
    logic rr_ptr_reg, rr_ptr_next;

    // A lone eligible source wins regardless of the pointer.
    always_comb begin
        if (elig[0] && elig[1]) begin
            winner = rr_ptr_reg;
        end else begin
            winner = ~elig[0];
        end
        rr_ptr_next = load_en ? ~winner : rr_ptr_reg;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_reg <= 1'b0;
        end else begin
            rr_ptr_reg <= rr_ptr_next;
        end
    end
`endif

    // Output register occupancy: accepting and reloading may happen in the same cycle.
    always_comb begin
        state_next    = state_reg;
        out_data_next = out_data_reg;
        out_src_next  = out_src_reg;
        rd_done_next  = '0;
        load_en       = 1'b0;
        load_ok       = (state_reg == ST_EMPTY) || bus.out_ready;

        if (load_ok && (elig != '0)) begin
            load_en              = 1'b1;
            state_next           = ST_FULL;
            out_data_next        = src_data[winner];
            out_src_next         = winner;
            rd_done_next[winner] = 1'b1;
        end else if ((state_reg == ST_FULL) && bus.out_ready) begin
            state_next = ST_EMPTY;
        end
    end

    always_comb begin
        hold_next    = hold_reg;
        pop_cnt_next = pop_cnt_reg;
        for (int i = 0; i < NSRC; i++) begin
            if (rd_done_next[i]) begin
                hold_next[i] = HOLD_LOAD;
            end else if (hold_reg[i] != '0) begin
                hold_next[i] = hold_reg[i] - HOLD_W'(1);
            end
            pop_cnt_next[i] = pop_cnt_reg[i] + 16'(rd_done_next[i]);
        end
    end

    // Async clear drops any in-flight pop pulse, so the FIFO head is kept.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= ST_EMPTY;
            out_data_reg <= '0;
            out_src_reg  <= 1'b0;
            rd_done_reg  <= '0;
            hold_reg     <= '0;
            pop_cnt_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            out_data_reg <= out_data_next;
            out_src_reg  <= out_src_next;
            rd_done_reg  <= rd_done_next;
            hold_reg     <= hold_next;
            pop_cnt_reg  <= pop_cnt_next;
        end
    end

    assign bus.out_valid    = (state_reg == ST_FULL);
    assign bus.out_data     = out_data_reg;
    assign bus.out_src      = out_src_reg;
    assign bus.src0_rd_done = rd_done_reg[0];
    assign bus.src1_rd_done = rd_done_reg[1];
    assign bus.pop_cnt0     = pop_cnt_reg[0];
    assign bus.pop_cnt1     = pop_cnt_reg[1];

    a_one_pop_per_cycle: assert property (
        @(posedge clock) disable iff (!reset_n) !(rd_done_reg[0] && rd_done_reg[1]));

    generate
        for (gi = 0; gi < NSRC; gi++) begin : g_chk
            a_pop_starts_hold: assert property (
                @(posedge clock) disable iff (!reset_n)
                rd_done_reg[gi] |-> (hold_reg[gi] == HOLD_LOAD));
        end
    endgenerate
endmodule

// File: tb/tb_ocx_tlx_fifo_drain_arb.sv
// Randomized bench for the FIFO drain arbiter against a cycle-timestamp reference model.
module tb_ocx_tlx_fifo_drain_arb;
    localparam int DW   = 514;
    localparam int HOLD = 2;

    logic clock = 1'b0;
    logic reset_n;

    ocx_tlx_fifo_drain_arb_if #(.DATA_WIDTH(DW)) bus ();

    ocx_tlx_fifo_drain_arb #(.DATA_WIDTH(DW), .HOLD_CYCLES(HOLD)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int loads  = 0;

    // Reference state: a source becomes eligible again at cycle next_ok.
    logic          m_valid;
    logic          m_src;
    logic          m_pref;
    logic [DW-1:0] m_data;
    logic [1:0]    m_rd;
    logic [15:0]   m_pop [2];
    int            next_ok [2];

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [543:0] t;
        for (int i = 0; i < 17; i++) t[i*32 +: 32] = $urandom;
        return t[DW-1:0];
    endfunction

    task automatic set_in(input logic a0, input logic a1, input logic rdy);
        bus.src0_avail = a0;
        bus.src1_avail = a1;
        bus.src0_data  = rand_data();
        bus.src1_data  = rand_data();
        bus.out_ready  = rdy;
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_src   = 1'b0;
        m_pref  = 1'b0;
        m_data  = '0;
        m_rd    = 2'b00;
        for (int i = 0; i < 2; i++) begin
            m_pop[i]   = 16'h0000;
            next_ok[i] = cyc;
        end
    endtask

    task automatic model_step();
        logic [1:0] e;
        logic       w;
        e[0] = bus.src0_avail && (cyc >= next_ok[0]);
        e[1] = bus.src1_avail && (cyc >= next_ok[1]);
        m_rd = 2'b00;
        if ((!m_valid || bus.out_ready) && (e != 2'b00)) begin
`ifdef OCX_TLX_DRAIN_ARB_STRICT_PRIO_EN
            w = e[0] ? 1'b0 : 1'b1;
`else
            w = e[m_pref] ? m_pref : !m_pref;
`endif
            m_valid    = 1'b1;
            m_src      = w;
            m_data     = w ? bus.src1_data : bus.src0_data;
            m_rd[w]    = 1'b1;
            m_pop[w]   = 16'(m_pop[w] + 16'd1);
            next_ok[w] = cyc + HOLD + 1;
            m_pref     = !w;
            loads++;
            $display("load cyc=%0d src=%0d pop0=%0d pop1=%0d", cyc, w, m_pop[0], m_pop[1]);
        end else if (m_valid && bus.out_ready) begin
            m_valid = 1'b0;
        end
        cyc++;
    endtask

    task automatic check_all();
        chk("out_valid", DW'(bus.out_valid), DW'(m_valid));
        chk("out_src", DW'(bus.out_src), DW'(m_src));
        chk("out_data", bus.out_data, m_data);
        chk("rd_done0", DW'(bus.src0_rd_done), DW'(m_rd[0]));
        chk("rd_done1", DW'(bus.src1_rd_done), DW'(m_rd[1]));
        chk("pop_cnt0", DW'(bus.pop_cnt0), DW'(m_pop[0]));
        chk("pop_cnt1", DW'(bus.pop_cnt1), DW'(m_pop[1]));
    endtask

    task automatic run_cycle();
        @(posedge clock);
        model_step();
        @(negedge clock);
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            set_in(1'b0, 1'b0, 1'b1);
            run_cycle();
        end
    endtask

    initial begin
        logic [DW-1:0] a5;
        logic [15:0]   p0_start;
        logic [15:0]   p1_start;
        int            l_start;
        int            n;
        int            prev_load;

        a5 = '0;
        for (int i = 0; i < 64; i++) a5[i*8 +: 8] = 8'hA5;
        a5[513:512] = 2'b01;

        // Reset held with both sources available
        reset_n = 1'b1;
        set_in(1'b1, 1'b1, 1'b1);
        model_reset();
        #1 reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check_all();
        end
        reset_n = 1'b1;
        run_cycle();
        chk("first_load_valid", DW'(bus.out_valid), DW'(1'b1));
        chk("first_load_src", DW'(bus.out_src), DW'(1'b0));

        // Both sources busy: alternate, 4 pops each over 8 loads
        idle(4);
        p0_start = m_pop[0];
        p1_start = m_pop[1];
        l_start  = loads;
        n = 0;
        while ((loads - l_start) < 8 && n < 40) begin
            set_in(1'b1, 1'b1, 1'b1);
            run_cycle();
            n++;
        end
        chk("rr_done", DW'(loads - l_start), DW'(8));
        chk("rr_pop0_delta", DW'(16'(bus.pop_cnt0 - p0_start)), DW'(4));
        chk("rr_pop1_delta", DW'(16'(bus.pop_cnt1 - p1_start)), DW'(4));

        // Only src1 busy: one load every HOLD+1 cycles
        idle(4);
        prev_load = -1;
        for (int i = 0; i < 15; i++) begin
            set_in(1'b0, 1'b1, 1'b1);
            run_cycle();
            if (m_rd[1]) begin
                if (prev_load >= 0) chk("single_gap", DW'(cyc - prev_load), DW'(HOLD + 1));
                prev_load = cyc;
            end
        end

        // Backpressure on an 0xA5 entry
        idle(4);
        set_in(1'b1, 1'b0, 1'b1);
        bus.src0_data = a5;
        run_cycle();
        chk("bp_load_src", DW'(bus.out_src), DW'(1'b0));
        for (int i = 0; i < 5; i++) begin
            set_in(1'b1, 1'b1, 1'b0);
            run_cycle();
            chk("bp_data_stable", bus.out_data, a5);
            chk("bp_no_pop", DW'({bus.src1_rd_done, bus.src0_rd_done}), DW'(2'b00));
        end
        set_in(1'b1, 1'b1, 1'b1);
        run_cycle();
        chk("bp_reload_pop", DW'(bus.src0_rd_done | bus.src1_rd_done), DW'(1'b1));

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            set_in($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 60,
                   $urandom_range(0, 99) < 70);
            run_cycle();
        end

        // Counter wrap, then reset asserted during the wrapping pop pulse
        idle(5);
        dut.pop_cnt_reg[0] = 16'hFFFE;
        m_pop[0] = 16'hFFFE;
        n = 0;
        while (m_pop[0] != 16'h0000 && n < 20) begin
            set_in(1'b1, 1'b0, 1'b1);
            run_cycle();
            n++;
        end
        chk("wrap_reached", DW'(m_pop[0] == 16'h0000), DW'(1'b1));
        chk("wrap_cnt0", DW'(bus.pop_cnt0), DW'(16'h0000));
        chk("wrap_rd_done0", DW'(bus.src0_rd_done), DW'(1'b1));
        #1 reset_n = 1'b0;
        #1;
        chk("areset_rd_done0", DW'(bus.src0_rd_done), DW'(1'b0));
        chk("areset_out_valid", DW'(bus.out_valid), DW'(1'b0));
        model_reset();
        @(negedge clock);
        check_all();
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            set_in(1'b1, 1'b1, 1'b1);
            run_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
